toggle_pulse_gen: RTL and testbench



---
 rtl/toggle_pulse_gen.sv | 133 +++++++++++++
 tb/tb_toggle_pulse_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_pulse_gen.sv
// Push-button conditioner: 2-FF sync, counter debounce, press/hold/repeat FSM.
// Ports: clk, res (sync, active high), btn_in (raw), repeat_en -> t_out, btn_level, held.
module toggle_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic res,
  input  logic btn_in,
  input  logic repeat_en,
  output logic t_out,
  output logic btn_level,
  output logic held
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] db_cnt;
  logic             commit;
  logic             commit_rise;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nx;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_nx;
  logic             t_nx;

  // A level change is accepted on the DEBOUNCE_CYCLES-th
  // consecutive mismatching cycle.
  assign commit      = (s2 != btn_level) && (db_cnt == DB_LAST);
  assign commit_rise = commit && s2;

  always_ff @(posedge clk) begin
    if (res) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      btn_level <= 1'b0;
      db_cnt    <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      if (s2 == btn_level) begin
        db_cnt <= '0;
      end else if (commit) begin
        btn_level <= s2;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + ONE;
      end
    end
  end

  // Release (btn_level low) is tested first so expiry
  // never fires a pulse once the release is visible.
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    rep_nx   = rep_cnt;
    t_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (commit_rise) begin
          state_nx = PRESSED;
          t_nx     = 1'b1;
          hold_nx  = '0;
        end
      end
      PRESSED: begin
        if (!btn_level) begin
          state_nx = IDLE;
        end else if (repeat_en) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nx = REPEAT;
            t_nx     = 1'b1;
            rep_nx   = '0;
          end else begin
            hold_nx = hold_cnt + ONE;
          end
        end else begin
          hold_nx = '0;
        end
      end
      REPEAT: begin
        if (!btn_level) begin
          state_nx = IDLE;
        end else if (!repeat_en) begin
          state_nx = PRESSED;
          hold_nx  = '0;
        end else if (rep_cnt == REP_LAST) begin
          t_nx   = 1'b1;
          rep_nx = '0;
        end else begin
          rep_nx = rep_cnt + ONE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rep_cnt  <= '0;
      t_out    <= 1'b0;
      held     <= 1'b0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      rep_cnt  <= rep_nx;
      t_out    <= t_nx;
      held     <= (state_nx == REPEAT);
    end
  end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Bench for toggle_pulse_gen: directed scenarios then random button traffic,
// compared each edge against a deadline-based reference model.
module tb_toggle_pulse_gen;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic btn_in = 1'b0;
  logic repeat_en = 1'b0;
  logic t_out;
  logic btn_level;
  logic held;

  toggle_pulse_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .res(res),
    .btn_in(btn_in),
    .repeat_en(repeat_en),
    .t_out(t_out),
    .btn_level(btn_level),
    .held(held)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int first_pulse = -1;
  int npulse = 0;

  // Reference model: raw samples history, mismatch run length,
  // and an absolute edge deadline for the next hold/repeat pulse.
  bit m_samp[$];
  bit m_lvl = 1'b0;
  int m_run = 0;
  bit m_press = 1'b0;
  bit m_rep = 1'b0;
  int m_dl = 0;
  bit m_t = 1'b0;

  task automatic chk(string tag, logic got, logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s edge %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_int(string tag, int got, int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit d;
    bit old;
    bit commit;
    m_t = 1'b0;
    if (res) begin
      m_samp.delete();
      m_lvl = 1'b0;
      m_run = 0;
      m_press = 1'b0;
      m_rep = 1'b0;
      m_dl = 0;
      return;
    end
    d = (m_samp.size() == 2) ? m_samp[0] : 1'b0;
    m_samp.push_back(btn_in);
    if (m_samp.size() > 2) void'(m_samp.pop_front());
    old = m_lvl;
    commit = 1'b0;
    if (d != m_lvl) begin
      m_run++;
      if (m_run == DEB) begin
        m_lvl = d;
        m_run = 0;
        commit = 1'b1;
      end
    end else begin
      m_run = 0;
    end
    if (!m_press) begin
      if (commit && d) begin
        m_press = 1'b1;
        m_rep = 1'b0;
        m_t = 1'b1;
        m_dl = cyc + HOLD;
      end
    end else if (!old) begin
      m_press = 1'b0;
      m_rep = 1'b0;
    end else if (!repeat_en) begin
      m_rep = 1'b0;
      m_dl = cyc + HOLD;
    end else if (cyc == m_dl) begin
      m_t = 1'b1;
      m_rep = 1'b1;
      m_dl = cyc + REP;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("t_out", t_out, m_t);
    chk("btn_level", btn_level, m_lvl);
    chk("held", held, m_press && m_rep);
    if (t_out === 1'b1) begin
      npulse++;
      if (first_pulse < 0) first_pulse = cyc;
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int r;
    int k;
    int m;
    int len;

    // reset with button high, then release
    res = 1'b1;
    btn_in = 1'b1;
    ticks(2);
    chk("rst_t_out", t_out, 1'b0);
    chk("rst_level", btn_level, 1'b0);
    r = cyc;
    res = 1'b0;
    first_pulse = -1;
    npulse = 0;
    ticks(10);
    chk_int("rst_release_pulse_edge", first_pulse, r + 6);
    chk_int("rst_release_npulse", npulse, 1);

    // clean press/release, no repeat
    res = 1'b1;
    tick();
    res = 1'b0;
    btn_in = 1'b0;
    repeat_en = 1'b0;
    ticks(8);
    k = cyc + 1;
    btn_in = 1'b1;
    first_pulse = -1;
    npulse = 0;
    ticks(30);
    chk_int("press_edge", first_pulse, k + 5);
    chk_int("press_npulse", npulse, 1);
    btn_in = 1'b0;
    ticks(4);
    chk("release_early", btn_level, 1'b1);
    ticks(1);
    chk("release_j4", btn_level, 1'b1);
    ticks(1);
    chk("release_j5", btn_level, 1'b0);
    chk_int("release_npulse", npulse, 1);
    ticks(4);

    // bounce then steady
    first_pulse = -1;
    npulse = 0;
    btn_in = 1'b1; ticks(3);
    btn_in = 1'b0; ticks(1);
    btn_in = 1'b1; ticks(2);
    btn_in = 1'b0; ticks(2);
    m = cyc + 1;
    btn_in = 1'b1;
    ticks(12);
    chk_int("bounce_edge", first_pulse, m + 5);
    chk_int("bounce_npulse", npulse, 1);
    btn_in = 1'b0;
    ticks(10);

    // auto-repeat
    repeat_en = 1'b1;
    k = cyc + 1;
    btn_in = 1'b1;
    first_pulse = -1;
    npulse = 0;
    ticks(14);
    chk_int("rep_press_edge", first_pulse, k + 5);
    chk("rep_first", t_out, 1'b1);
    chk("rep_held", held, 1'b1);
    ticks(4);
    chk("rep_second", t_out, 1'b1);

    // drop repeat_en in REPEAT
    repeat_en = 1'b0;
    ticks(1);
    chk("drop_held", held, 1'b0);
    npulse = 0;
    ticks(6);
    chk_int("drop_npulse", npulse, 0);
    repeat_en = 1'b1;
    ticks(8);
    chk("rearm_pulse", t_out, 1'b1);

    // reset during repeat with button held
    ticks(10);
    chk("pre_rst_held", held, 1'b1);
    res = 1'b1;
    tick();
    chk("midrst_t_out", t_out, 1'b0);
    chk("midrst_level", btn_level, 1'b0);
    chk("midrst_held", held, 1'b0);
    tick();
    r = cyc;
    res = 1'b0;
    first_pulse = -1;
    ticks(6);
    chk_int("midrst_press_edge", first_pulse, r + 6);
    ticks(8);
    chk("midrst_repeat", t_out, 1'b1);
    btn_in = 1'b0;
    ticks(10);

    // random traffic
    for (int b = 0; b < 80; b++) begin
      btn_in = 1'($urandom_range(0, 1));
      repeat_en = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) begin
        res = ($urandom_range(0, 150) == 0);
        if ($urandom_range(0, 9) == 0) begin
          btn_in = ~btn_in;
          tick();
          btn_in = ~btn_in;
        end else begin
          tick();
        end
      end
    end
    res = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
